// File: rtl/ula_pkg.sv
// Shared definitions for the multicycle ALU.
//   ula_op_e    : 3-bit opcode; encodings outside the enum are illegal and
//                 produce a zero result with the usual latency.
//   ula_state_e : control FSM states.
package ula_pkg;

  typedef enum logic [2:0] {
    ULA_ADD = 3'b000,
    ULA_SUB = 3'b001,
    ULA_AND = 3'b010,
    ULA_OR  = 3'b011,
    ULA_XOR = 3'b100
  } ula_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } ula_state_e;

  // ADD and SUB go through the carry chain and produce COUT/OVF.
  function automatic logic op_is_arith(logic [2:0] op);
    return (op == ULA_ADD) || (op == ULA_SUB);
  endfunction

endpackage

// File: rtl/ula_chunk_adder.sv
// CHUNK-bit ripple-carry adder slice.
//   a, b   : slice operands
//   cin    : carry into bit 0
//   sum    : slice sum
//   cout   : carry out of bit CHUNK-1
//   c_msb  : carry into bit CHUNK-1 (used for signed overflow on the top slice)
module ula_chunk_adder #(
  parameter int unsigned CHUNK = 1
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  always_comb begin
    logic carry;
    carry = cin;
    c_msb = cin;
    sum   = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      if (i == int'(CHUNK) - 1) c_msb = carry;
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
    end
    cout = carry;
  end

endmodule

// File: rtl/ula_multicycle.sv
// Multicycle ALU: ADD/SUB/AND/OR/XOR over WIDTH bits, processed CHUNK bits
// per cycle (least significant slice first) through a registered carry.
// Result appears WIDTH/CHUNK edges after the accepting edge and is held
// until delivered; the flag outputs hold their last value after delivery.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : request handshake (op, a, b, cin latched on accept)
//   op                   : opcode (see ula_pkg::ula_op_e)
//   a, b, cin            : operands, carry-in (ADD only)
//   out_valid / out_ready: result handshake
//   result, cout         : result and carry/no-borrow flag
//   zero, ovf            : result-is-zero and signed-overflow flags
//
// Build option: define ULA_FLAGS_EN to compute zero/ovf; otherwise both are
// tied low and the flag logic is not built. result/cout/timing are unchanged.
module ula_multicycle
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  if ((WIDTH % CHUNK) != 0) begin : gen_bad_chunk
    $error("ula_multicycle: WIDTH must be a multiple of CHUNK");
  end

  localparam int unsigned N        = WIDTH / CHUNK;
  localparam int unsigned CntW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  ula_state_e       state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;      // b_q holds ~B for SUB
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] res_sh_q;      // slices shift in from the top
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;

  logic             accept, deliver, is_arith;
  logic [CHUNK-1:0] a_sl, b_sl, slice_sum, slice_res;
  logic             slice_cout, slice_c_msb;
  logic [WIDTH-1:0] slice_ext, res_next;

  assign in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready);
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid_q & out_ready;
  assign is_arith  = op_is_arith(op_q);

  assign a_sl = a_q[CHUNK-1:0];
  assign b_sl = b_q[CHUNK-1:0];

  ula_chunk_adder #(
    .CHUNK (CHUNK)
  ) u_adder (
    .a     (a_sl),
    .b     (b_sl),
    .cin   (carry_q),
    .sum   (slice_sum),
    .cout  (slice_cout),
    .c_msb (slice_c_msb)
  );

  always_comb begin
    slice_res = '0;
    case (op_q)
      ULA_ADD, ULA_SUB: slice_res = slice_sum;
      ULA_AND:          slice_res = a_sl & b_sl;
      ULA_OR:           slice_res = a_sl | b_sl;
      ULA_XOR:          slice_res = a_sl ^ b_sl;
      default:          slice_res = '0;
    endcase
    slice_ext = WIDTH'(slice_res);
    res_next  = (res_sh_q >> CHUNK) | (slice_ext << (WIDTH - CHUNK));
  end

`ifdef ULA_FLAGS_EN
  logic zero_q, ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      res_sh_q    <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
`ifdef ULA_FLAGS_EN
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) state_q <= StBusy;
        end
        StBusy: begin
          a_q      <= a_q >> CHUNK;
          b_q      <= b_q >> CHUNK;
          carry_q  <= slice_cout;
          res_sh_q <= res_next;
          cnt_q    <= cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            state_q     <= StDone;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            result_q    <= res_next;
            cout_q      <= is_arith & slice_cout;
`ifdef ULA_FLAGS_EN
            zero_q      <= (res_next == '0);
            // Signed overflow: carry into MSB differs from carry out of MSB.
            ovf_q       <= is_arith & (slice_cout ^ slice_c_msb);
`endif
          end
        end
        StDone: begin
          if (deliver) begin
            out_valid_q <= 1'b0;
            state_q     <= accept ? StBusy : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Accept only happens in IDLE or DONE, so this never fights the shifts.
      if (accept) begin
        op_q    <= op;
        a_q     <= a;
        b_q     <= (op == ULA_SUB) ? ~b : b;
        carry_q <= (op == ULA_SUB) ? 1'b1 : ((op == ULA_ADD) & cin);
        cnt_q   <= '0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;

`ifdef ULA_FLAGS_EN
  assign zero = zero_q;
  assign ovf  = ovf_q;
`else
  logic unused_c_msb;
  assign unused_c_msb = slice_c_msb;
  assign zero = 1'b0;
  assign ovf  = 1'b0;
`endif

endmodule

// File: doc/ula_multicycle.md
ULA_MULTICYCLE -- requirements
Module: ula_multicycle

Interface
REQ-001 The block SHALL have parameters: WIDTH, 8, operand/result width in bits; CHUNK, 1, bits processed per cycle (WIDTH % CHUNK == 0, elaboration error otherwise).
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 IN_VALID  input  1  operation request valid.
REQ-005 IN_READY  output  1  block can accept a request this cycle.
REQ-006 OP  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, others illegal.
REQ-007 A, B  input  WIDTH  operands; CIN  input  1  carry-in (ADD only).
REQ-008 OUT_VALID  output  1  result valid; OUT_READY  input  1  consumer accepts result.
REQ-009 RESULT  output  WIDTH, COUT  output  1, ZERO  output  1, OVF  output  1  result and flags.

Function
REQ-010 Handshake: request accepted on a rising edge where IN_VALID and IN_READY are both 1; result delivered on an edge where OUT_VALID and OUT_READY are both 1.
REQ-011 FSM states: IDLE, BUSY, DONE; IDLE->BUSY on accept; BUSY->DONE after N = WIDTH/CHUNK BUSY cycles; DONE->IDLE on delivery without accept; DONE->BUSY on delivery with simultaneous accept.
REQ-012 IN_READY SHALL be 1 in IDLE, and in DONE only while OUT_READY is 1; 0 in BUSY.
REQ-013 OP, A, B, CIN SHALL be latched at accept; input changes during BUSY/DONE SHALL not affect the result.
REQ-014 BUSY processes one CHUNK-bit slice per cycle, least significant slice first, through a registered carry; OUT_VALID rises exactly N edges after the accepting edge.
REQ-015 ADD: RESULT = A + B + CIN mod 2^WIDTH, COUT = carry out of bit WIDTH-1.
REQ-016 SUB: RESULT = A + ~B + 1 mod 2^WIDTH, CIN ignored, COUT = 1 when no borrow (A >= B unsigned).
REQ-017 AND/OR/XOR: bitwise; COUT = 0, OVF = 0.
REQ-018 Illegal opcode: RESULT = 0, COUT = 0, OVF = 0, ZERO = 1, same latency N.
REQ-019 OVF (ADD/SUB) = signed overflow: MSB of A and of effective B (B for ADD, ~B for SUB) equal and MSB of RESULT differs.
REQ-020 ZERO = 1 when RESULT == 0, all opcodes.
REQ-021 RESULT, COUT, ZERO, OVF SHALL hold stable while OUT_VALID is 1 and OUT_READY is 0, and hold last value after delivery until the next DONE.

Reset
REQ-022 On RST_N low, immediately: state IDLE, OUT_VALID 0, RESULT 0, COUT 0, ZERO 0, OVF 0, carry and slice counter 0; IN_READY 1 after release.
REQ-023 Reset asserted in BUSY or DONE SHALL abandon the operation; no result is delivered for it.

Configuration
REQ-024 Macro ULA_FLAGS_EN: defined -> ZERO and OVF computed per REQ-019/020; undefined -> ZERO and OVF tied 0, flag logic absent; RESULT, COUT and timing identical in both builds.

Structure
REQ-025 Package ula_pkg SHALL hold the opcode enum (ULA_ADD, ULA_SUB, ULA_AND, ULA_OR, ULA_XOR) and the FSM state enum.
REQ-026 Sub-module ula_chunk_adder SHALL implement a CHUNK-bit ripple adder (carry in, carry out, carry into MSB) instantiated once.

Verification (WIDTH=8, CHUNK=1 unless stated)
REQ-027 ADD A=0xFF B=0x01 CIN=0 -> after 8 edges OUT_VALID=1, RESULT=0x00, COUT=1, ZERO=1, OVF=0.
REQ-028 SUB A=0x80 B=0x01 -> RESULT=0x7F, COUT=1, OVF=1, ZERO=0; SUB A=0x01 B=0x02 -> RESULT=0xFF, COUT=0.
REQ-029 OUT_READY held 0 for 5 cycles in DONE with A/B toggling -> outputs constant, IN_READY=0; OUT_READY=1 with IN_VALID=1 (OR 0xF0,0x0F) -> back-to-back accept, next RESULT=0xFF after 8 edges.
REQ-030 RST_N pulsed low at BUSY cycle 4 -> OUT_VALID=0, all outputs 0, no result delivered; next ADD 0x03+0x04 -> 0x07.
REQ-031 OP=111 A=0x55 B=0xAA -> RESULT=0x00, ZERO=1, COUT=0; build without ULA_FLAGS_EN -> ZERO=0, OVF=0 always.
REQ-032 WIDTH=16 CHUNK=4: ADD 0x7FFF+0x0001 -> OUT_VALID after 4 edges, RESULT=0x8000, OVF=1, COUT=0.
